// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60 VGA.
// Produces scan position, active flag, line/frame strobes and delayed syncs.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pxl_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pxl_en,
  output logic       line_pulse,
  output logic       frame_pulse,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] H_SS     = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SS     = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);

  logic [2:0]            div_q, div_d;
  logic [9:0]            h_q, h_d;
  logic [9:0]            v_q, v_d;
  logic [9:0]            x_q, y_q;
  logic                  act_q, lp_q, fp_q;
  logic [SYNC_DELAY:0]   hs_q, hs_d;
  logic [SYNC_DELAY:0]   vs_q, vs_d;
  logic                  tick;
  logic                  h_wrap;
  logic [10:0]           hx, vx;
  logic                  act_raw, hs_raw, vs_raw;

  assign tick    = en & ~rst & (div_q == DIV_LAST);
  assign h_wrap  = (h_q == H_LAST);
  assign hx      = {1'b0, h_q};
  assign vx      = {1'b0, v_q};
  assign act_raw = (hx < H_ACT) & (vx < V_ACT);
  assign hs_raw  = (hx >= H_SS) & (hx < H_SE);
  assign vs_raw  = (vx >= V_SS) & (vx < V_SE);

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (en) begin
      div_d = tick ? 3'd0 : div_q + 3'd1;
    end
    if (tick) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end
      // Sync pipeline index 0 is level with x/y; the top stage drives the pin.
      hs_d[0] = hs_raw;
      vs_d[0] = vs_raw;
      for (int i = 1; i <= SYNC_DELAY; i++) begin
        hs_d[i] = hs_q[i-1];
        vs_d[i] = vs_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      act_q <= 1'b0;
      lp_q  <= 1'b0;
      fp_q  <= 1'b0;
      hs_q  <= '0;
      vs_q  <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      lp_q  <= tick & (h_q == 10'd0);
      fp_q  <= tick & (h_q == 10'd0) & (vx == V_ACT);
      if (tick) begin
        x_q   <= h_q;
        y_q   <= v_q;
        act_q <= act_raw;
      end
    end
  end

  assign pxl_tick    = tick;
  assign x           = x_q;
  assign y           = y_q;
  assign pxl_en      = act_q & en;
  assign line_pulse  = lp_q & en;
  assign frame_pulse = fp_q & en;
  assign hsync       = HS_POL ? hs_q[SYNC_DELAY] : ~hs_q[SYNC_DELAY];
  assign vsync       = VS_POL ? vs_q[SYNC_DELAY] : ~vs_q[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances checked every cycle
// against a tick-count arithmetic model of the raster.
module tb_vga_timing_gen;

  typedef struct packed {
    bit       tick;
    bit [9:0] x;
    bit [9:0] y;
    bit       pen;
    bit       lp;
    bit       fp;
    bit       hs;
    bit       vs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  logic       t0, pe0, lp0, fp0, hs0, vs0;
  logic [9:0] x0, y0;
  logic       t2, pe2, lp2, fp2, hs2, vs2;
  logic [9:0] x2, y2;
  logic       ts, pes, lps, fps, hss, vss;
  logic [9:0] xs, ys;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ecnt   = 0;
  bit last_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(.SYNC_DELAY(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .pxl_tick(t0), .x(x0), .y(y0),
    .pxl_en(pe0), .line_pulse(lp0), .frame_pulse(fp0),
    .hsync(hs0), .vsync(vs0)
  );

  vga_timing_gen #(.SYNC_DELAY(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .pxl_tick(t2), .x(x2), .y(y2),
    .pxl_en(pe2), .line_pulse(lp2), .frame_pulse(fp2),
    .hsync(hs2), .vsync(vs2)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(3), .SYNC_DELAY(1)
  ) us (
    .clk(clk), .rst(rst), .en(en), .pxl_tick(ts), .x(xs), .y(ys),
    .pxl_en(pes), .line_pulse(lps), .frame_pulse(fps),
    .hsync(hss), .vsync(vss)
  );

  // Position k is the k-th tick since reset; ticks completed = enabled edges / div.
  function automatic exp_t model(
    int ec, bit le, bit e, bit r, int div,
    int ha, int hfp, int hsw, int hbp,
    int va, int vfp, int vsw, int vbp,
    int dly, bit hp, bit vp
  );
    exp_t res;
    int ht, vt, nk, k, h, v, j, hj, vj;
    bit ee;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    res = '0;
    res.hs = !hp;
    res.vs = !vp;
    ee = e && !r;
    res.tick = ee && (ec % div == div - 1);
    nk = ec / div;
    if (nk > 0) begin
      k = nk - 1;
      h = k % ht;
      v = (k / ht) % vt;
      res.x   = 10'(h);
      res.y   = 10'(v);
      res.pen = ee && h < ha && v < va;
      res.lp  = ee && le && (ec % div == 0) && h == 0;
      res.fp  = res.lp && v == va;
      j = k - dly;
      if (j >= 0) begin
        hj = j % ht;
        vj = (j / ht) % vt;
        if (hj >= ha + hfp && hj < ha + hfp + hsw) res.hs = hp;
        if (vj >= va + vfp && vj < va + vfp + vsw) res.vs = vp;
      end
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_dut(input string n, input exp_t e,
                         input logic t, input logic [9:0] xx,
                         input logic [9:0] yy, input logic pe,
                         input logic lp, input logic fp,
                         input logic hs, input logic vs);
    chk({n, ".pxl_tick"}, {31'd0, t}, {31'd0, e.tick});
    chk({n, ".x"}, {22'd0, xx}, {22'd0, e.x});
    chk({n, ".y"}, {22'd0, yy}, {22'd0, e.y});
    chk({n, ".pxl_en"}, {31'd0, pe}, {31'd0, e.pen});
    chk({n, ".line_pulse"}, {31'd0, lp}, {31'd0, e.lp});
    chk({n, ".frame_pulse"}, {31'd0, fp}, {31'd0, e.fp});
    chk({n, ".hsync"}, {31'd0, hs}, {31'd0, e.hs});
    chk({n, ".vsync"}, {31'd0, vs}, {31'd0, e.vs});
  endtask

  task automatic check_all();
    exp_t e0, e2, es;
    e0 = model(ecnt, last_en, en, rst, 2, 640, 16, 96, 48,
               480, 10, 2, 33, 0, 1'b0, 1'b0);
    e2 = model(ecnt, last_en, en, rst, 2, 640, 16, 96, 48,
               480, 10, 2, 33, 2, 1'b0, 1'b0);
    es = model(ecnt, last_en, en, rst, 3, 8, 2, 3, 3,
               6, 2, 2, 3, 1, 1'b1, 1'b0);
    chk_dut("u0", e0, t0, x0, y0, pe0, lp0, fp0, hs0, vs0);
    chk_dut("u2", e2, t2, x2, y2, pe2, lp2, fp2, hs2, vs2);
    chk_dut("us", es, ts, xs, ys, pes, lps, fps, hss, vss);
  endtask

  task automatic step(input bit ne, input bit nr);
    @(posedge clk);
    cyc++;
    if (!rst && en) ecnt++;
    last_en = !rst && en;
    #2;
    en  = ne;
    rst = nr;
    if (nr) begin
      ecnt    = 0;
      last_en = 1'b0;
    end
    #2;
    check_all();
  endtask

  function automatic bit main_at(int col);
    return ecnt > 0 && ecnt % 2 == 0 && ((ecnt / 2) - 1) % 800 == col;
  endfunction

  initial begin
    #1;
    check_all();
    repeat (3) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (1700) step(1'b1, 1'b0);

    for (int i = 0; i < 2000 && !main_at(300); i++) step(1'b1, 1'b0);
    chk("reach_x300", {31'd0, main_at(300)}, 32'd1);
    repeat (37) step(1'b0, 1'b0);
    repeat (1700) step(1'b1, 1'b0);

    repeat (3000) step($urandom_range(0, 9) != 0, 1'b0);

    for (int i = 0; i < 2000 && !main_at(500); i++) step(1'b1, 1'b0);
    chk("reach_x500", {31'd0, main_at(500)}, 32'd1);
    #1;
    rst     = 1'b1;
    ecnt    = 0;
    last_en = 1'b0;
    #1;
    check_all();
    repeat (2) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (1700) step(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
